// File: rtl/pong_pkg.sv
// Shared types and defaults for the pong game blocks.
// Holds the game-state encoding used by the scorekeeper.
package pong_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_WAIT,
    PLAY,
    OVER
  } state_t;

  localparam int DEFAULT_SCORE_LIMIT = 15;
  localparam int DEFAULT_SERVE_DELAY = 50000000;

endpackage : pong_pkg

// File: rtl/rise_detect.sv
// Single-bit rising-edge detector.
// History resets high so an input already high at reset never looks like a new edge.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic rise
);

  logic prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= in;
    end
  end

  assign rise = in & ~prev_q;

endmodule : rise_detect

// File: rtl/score_keeper.sv
// Pong scorekeeper: counts goal edges, times serves, detects the winner.
// All outputs are registered; new_game overrides every other input.
module score_keeper
  import pong_pkg::*;
#(
  parameter int SCORE_LIMIT = DEFAULT_SCORE_LIMIT,
  parameter int SERVE_DELAY = DEFAULT_SERVE_DELAY
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p1_goal,
  input  logic        p2_goal,
  input  logic        new_game,
  output logic [31:0] p1_score,
  output logic [31:0] p2_score,
  output logic        p1_win,
  output logic        p2_win,
  output logic        serve,
  output logic        serve_dir,
  output logic        playing
);

  localparam int              CW       = $clog2(SERVE_DELAY + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(SERVE_DELAY - 1);
  localparam logic [31:0]     LIMIT    = 32'(SCORE_LIMIT);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   p1_score_q, p1_score_d;
  logic [31:0]   p2_score_q, p2_score_d;
  logic [31:0]   p1_inc, p2_inc;
  logic          p1_win_q, p1_win_d;
  logic          p2_win_q, p2_win_d;
  logic          serve_q, serve_d;
  logic          dir_q, dir_d;
  logic          playing_q;
  logic          p1_rise, p2_rise;

  rise_detect u_p1_rise (
    .clk   (clk),
    .reset (reset),
    .in    (p1_goal),
    .rise  (p1_rise)
  );

  rise_detect u_p2_rise (
    .clk   (clk),
    .reset (reset),
    .in    (p2_goal),
    .rise  (p2_rise)
  );

  assign p1_inc = p1_score_q + 32'd1;
  assign p2_inc = p2_score_q + 32'd1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    p1_score_d = p1_score_q;
    p2_score_d = p2_score_q;
    p1_win_d   = p1_win_q;
    p2_win_d   = p2_win_q;
    serve_d    = 1'b0;
    dir_d      = dir_q;

    if (new_game) begin
      state_d    = SERVE_WAIT;
      cnt_d      = '0;
      p1_score_d = '0;
      p2_score_d = '0;
      p1_win_d   = 1'b0;
      p2_win_d   = 1'b0;
      dir_d      = 1'b0;
    end else begin
      case (state_q)
        IDLE: ;
        SERVE_WAIT: begin
          if (cnt_q == CNT_LAST) begin
            serve_d = 1'b1;
            state_d = PLAY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        PLAY: begin
          // A tied goal is treated as a dead ball: re-serve the same way.
          if (p1_rise && p2_rise) begin
            state_d = SERVE_WAIT;
            cnt_d   = '0;
          end else if (p1_rise) begin
            p1_score_d = p1_inc;
            if (p1_inc == LIMIT) begin
              p1_win_d = 1'b1;
              state_d  = OVER;
            end else begin
              state_d = SERVE_WAIT;
              cnt_d   = '0;
              dir_d   = 1'b0;
            end
          end else if (p2_rise) begin
            p2_score_d = p2_inc;
            if (p2_inc == LIMIT) begin
              p2_win_d = 1'b1;
              state_d  = OVER;
            end else begin
              state_d = SERVE_WAIT;
              cnt_d   = '0;
              dir_d   = 1'b1;
            end
          end
        end
        OVER: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      p1_score_q <= '0;
      p2_score_q <= '0;
      p1_win_q   <= 1'b0;
      p2_win_q   <= 1'b0;
      serve_q    <= 1'b0;
      dir_q      <= 1'b0;
      playing_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      p1_score_q <= p1_score_d;
      p2_score_q <= p2_score_d;
      p1_win_q   <= p1_win_d;
      p2_win_q   <= p2_win_d;
      serve_q    <= serve_d;
      dir_q      <= dir_d;
      playing_q  <= (state_d == PLAY);
    end
  end

  assign p1_score  = p1_score_q;
  assign p2_score  = p2_score_q;
  assign p1_win    = p1_win_q;
  assign p2_win    = p2_win_q;
  assign serve     = serve_q;
  assign serve_dir = dir_q;
  assign playing   = playing_q;

endmodule : score_keeper

// File: tb/tb_score_keeper.sv
// Directed self-checking bench for score_keeper with SCORE_LIMIT=3, SERVE_DELAY=4.
// Inputs change and outputs are sampled 1 time unit after each rising clock edge.
module tb_score_keeper;

  logic        clk;
  logic        reset;
  logic        p1_goal;
  logic        p2_goal;
  logic        new_game;
  logic [31:0] p1_score;
  logic [31:0] p2_score;
  logic        p1_win;
  logic        p2_win;
  logic        serve;
  logic        serve_dir;
  logic        playing;

  int compared   = 0;
  int mismatched = 0;

  score_keeper #(
    .SCORE_LIMIT (3),
    .SERVE_DELAY (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .p1_goal   (p1_goal),
    .p2_goal   (p2_goal),
    .new_game  (new_game),
    .p1_score  (p1_score),
    .p2_score  (p2_score),
    .p1_win    (p1_win),
    .p2_win    (p2_win),
    .serve     (serve),
    .serve_dir (serve_dir),
    .playing   (playing)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic g1, input logic g2, input logic ng);
    p1_goal  = g1;
    p2_goal  = g2;
    new_game = ng;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Counts cycles from SERVE_WAIT entry to the serve pulse, then confirms PLAY follows.
  task automatic waitServe(input string tag, input int expCycles, input logic expDir);
    int  n    = 0;
    bit  seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick(1);
      n++;
      if (serve === 1'b1) seen = 1'b1;
    end
    checkOutput({tag, "_latency"}, n, expCycles);
    checkOutput({tag, "_dir"}, serve_dir, expDir);
    tick(1);
    checkOutput({tag, "_pulse_end"}, serve, 1'b0);
    checkOutput({tag, "_playing"}, playing, 1'b1);
  endtask

  task automatic scoreGoal(input logic g1, input logic g2);
    applyStimulus(g1, g2, 1'b0);
    tick(1);
    applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick(2);
    checkOutput("rst_p1", p1_score, 0);
    checkOutput("rst_p2", p2_score, 0);
    checkOutput("rst_p1win", p1_win, 0);
    checkOutput("rst_p2win", p2_win, 0);
    checkOutput("rst_serve", serve, 0);
    checkOutput("rst_dir", serve_dir, 0);
    checkOutput("rst_playing", playing, 0);
    reset = 1'b0;
    tick(1);
    checkOutput("idle_playing", playing, 0);

    // First game start
    applyStimulus(1'b0, 1'b0, 1'b1);
    tick(1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("sw_serve", serve, 0);
    checkOutput("sw_playing", playing, 0);
    waitServe("serve0", 4, 1'b0);

    // p1_goal held for 10 cycles gives one point; p2 edge during serve wait ignored
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick(1);
    checkOutput("hold_p1", p1_score, 1);
    checkOutput("hold_playing", playing, 0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    tick(1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitServe("serve1", 3, 1'b0);
    tick(4);
    checkOutput("hold_p1_after", p1_score, 1);
    checkOutput("hold_p2_after", p2_score, 0);
    applyStimulus(1'b0, 1'b0, 1'b0);

    // New game, then p2 wins three rallies
    applyStimulus(1'b0, 1'b0, 1'b1);
    tick(1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("ng_clear_p1", p1_score, 0);
    waitServe("serve2", 4, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      scoreGoal(1'b0, 1'b1);
      checkOutput("rally_p2", p2_score, k);
      checkOutput("rally_p1", p1_score, 0);
      if (k < 3) waitServe("rally_serve", 4, 1'b1);
    end
    checkOutput("p2win", p2_win, 1);
    checkOutput("p2win_p1win", p1_win, 0);
    checkOutput("over_playing", playing, 0);
    scoreGoal(1'b1, 1'b0);
    scoreGoal(1'b0, 1'b1);
    tick(6);
    checkOutput("over_p1", p1_score, 0);
    checkOutput("over_p2", p2_score, 3);
    checkOutput("over_p2win", p2_win, 1);
    checkOutput("over_serve", serve, 0);

    // Simultaneous goals re-serve with direction unchanged
    applyStimulus(1'b0, 1'b0, 1'b1);
    tick(1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("ng2_p2win", p2_win, 0);
    waitServe("serve3", 4, 1'b0);
    scoreGoal(1'b0, 1'b1);
    checkOutput("g_p2", p2_score, 1);
    waitServe("serve4", 4, 1'b1);
    scoreGoal(1'b1, 1'b1);
    checkOutput("tie_p1", p1_score, 0);
    checkOutput("tie_p2", p2_score, 1);
    checkOutput("tie_playing", playing, 0);
    waitServe("reserve", 4, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      scoreGoal(1'b1, 1'b0);
      checkOutput("run_p1", p1_score, k);
      if (k < 3) waitServe("run_serve", 4, 1'b0);
    end
    checkOutput("p1win", p1_win, 1);
    checkOutput("p1win_p2win", p2_win, 0);
    checkOutput("p1win_p2", p2_score, 1);

    // new_game from OVER, and a second new_game mid-serve restarts the delay
    applyStimulus(1'b0, 1'b0, 1'b1);
    tick(1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("ng3_p1", p1_score, 0);
    checkOutput("ng3_p2", p2_score, 0);
    checkOutput("ng3_p1win", p1_win, 0);
    tick(2);
    checkOutput("mid_serve", serve, 0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    tick(1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitServe("restart", 4, 1'b0);

    // Build 2/1 then reset asynchronously with p1_goal held
    scoreGoal(1'b1, 1'b0);
    waitServe("s5", 4, 1'b0);
    scoreGoal(1'b1, 1'b0);
    waitServe("s6", 4, 1'b0);
    scoreGoal(1'b0, 1'b1);
    waitServe("s7", 4, 1'b1);
    checkOutput("pre_rst_p1", p1_score, 2);
    checkOutput("pre_rst_p2", p2_score, 1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("arst_p1", p1_score, 0);
    checkOutput("arst_p2", p2_score, 0);
    checkOutput("arst_playing", playing, 0);
    checkOutput("arst_dir", serve_dir, 0);
    tick(1);
    reset = 1'b0;
    tick(2);
    checkOutput("post_rst_p1", p1_score, 0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    tick(1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitServe("postreset", 4, 1'b0);
    tick(3);
    checkOutput("held_p1", p1_score, 0);
    checkOutput("held_p2", p2_score, 0);
    checkOutput("held_playing", playing, 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_score_keeper
